// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel-side signals of the VGA timing generator so the
// generator and its consumer (pattern / frame-buffer logic plus DAC pins)
// connect through one port.
//
//   en          pixel-clock enable, driven by the consumer side
//   colors      RGB332 pixel answering the request made PIX_LAT enables ago
//   hsync/vsync latency-aligned sync outputs
//   red/green/blue gated colour outputs
//   need_pixel  stage-0 pixel request
//   counterX/Y  stage-0 raster position
//   frame_start/line_start  enabled-cycle markers at x==0 (and y==0)
//
// The master modport is the timing generator; the slave modport is the
// consumer that supplies the enable and the pixel data.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int CW = 10
);
   logic          en;
   logic [7:0]    colors;
   logic          hsync;
   logic          vsync;
   logic [2:0]    red;
   logic [2:0]    green;
   logic [1:0]    blue;
   logic          need_pixel;
   logic [CW-1:0] counterX;
   logic [CW-1:0] counterY;
   logic          frame_start;
   logic          line_start;

   modport master (
      input  en, colors,
      output hsync, vsync, red, green, blue, need_pixel,
             counterX, counterY, frame_start, line_start
   );

   modport slave (
      output en, colors,
      input  hsync, vsync, red, green, blue, need_pixel,
             counterX, counterY, frame_start, line_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Two free-running counters walk
// the raster (active, front porch, sync, back porch on both axes) one pixel
// per enabled clock. The stage-0 position and pixel request go out to the
// pattern / frame-buffer logic; active, hsync and vsync are then delayed by
// PIX_LAT enabled cycles so they line up with the colour that logic returns.
//
// Ports
//   clk25MHz  pixel clock
//   rst       synchronous reset, active-high
//   vga       vga_timing_gen_if.master: en and colors in; sync, RGB,
//             need_pixel, counterX/Y, frame_start, line_start out
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter int PIX_LAT   = 2,
   parameter int CW        = 10
) (
   input logic              clk25MHz,
   input logic              rst,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   localparam bit HS_IDLE = ~HSYNC_POL;
   localparam bit VS_IDLE = ~VSYNC_POL;

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;

   logic raw_active;
   logic raw_hs;
   logic raw_vs;

   logic dly_active;
   logic dly_hs;
   logic dly_vs;

   // Next raster position. The vertical counter only steps on the last
   // pixel of a line, and both wrap so y never reaches V_TOTAL.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (vga.en) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
         end else begin
            x_d = x_q + CW'(1);
         end
      end
   end

   // Raster counters. Reset wins over the enable so a reset always lands
   // on the first visible pixel of a new frame.
   always_ff @(posedge clk25MHz) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   // Stage-0 decode. Sync is kept at its final pin level here so the delay
   // line just carries levels and reset can preload the idle level.
   always_comb begin
      raw_active = (x_q < H_ACT) && (y_q < V_ACT);
      raw_hs     = ((x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END)) ? HSYNC_POL : HS_IDLE;
      raw_vs     = ((y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END)) ? VSYNC_POL : VS_IDLE;
   end

   generate
      if (PIX_LAT == 0) begin : g_bypass
         // No pipeline in the pixel source: use the stage-0 decode directly.
         assign dly_active = raw_active;
         assign dly_hs     = raw_hs;
         assign dly_vs     = raw_vs;
      end else begin : g_delay
         logic [PIX_LAT-1:0] act_q, act_d;
         logic [PIX_LAT-1:0] hs_q, hs_d;
         logic [PIX_LAT-1:0] vs_q, vs_d;

         // Shift the stage-0 decode one step per enabled cycle; bit 0 takes
         // the newest value and the top bit is what reaches the pins.
         always_comb begin
            act_d = act_q;
            hs_d  = hs_q;
            vs_d  = vs_q;
            if (vga.en) begin
               act_d[0] = raw_active;
               hs_d[0]  = raw_hs;
               vs_d[0]  = raw_vs;
               for (int i = 1; i < PIX_LAT; i++) begin
                  act_d[i] = act_q[i-1];
                  hs_d[i]  = hs_q[i-1];
                  vs_d[i]  = vs_q[i-1];
               end
            end
         end

         // Reset flushes every stage to blank with idle syncs, so the first
         // PIX_LAT enabled cycles after a reset never show stale colour.
         always_ff @(posedge clk25MHz) begin
            if (rst) begin
               act_q <= '0;
               hs_q  <= {PIX_LAT{HS_IDLE}};
               vs_q  <= {PIX_LAT{VS_IDLE}};
            end else begin
               act_q <= act_d;
               hs_q  <= hs_d;
               vs_q  <= vs_d;
            end
         end

         assign dly_active = act_q[PIX_LAT-1];
         assign dly_hs     = hs_q[PIX_LAT-1];
         assign dly_vs     = vs_q[PIX_LAT-1];
      end
   endgenerate

   // Output drive. Colour is combinational from the incoming pixel so it
   // needs no extra register, but it is forced to zero whenever the
   // aligned position is outside the visible window.
   always_comb begin
      vga.hsync       = dly_hs;
      vga.vsync       = dly_vs;
      vga.red         = dly_active ? vga.colors[7:5] : 3'd0;
      vga.green       = dly_active ? vga.colors[4:2] : 3'd0;
      vga.blue        = dly_active ? vga.colors[1:0] : 2'd0;
      vga.need_pixel  = raw_active;
      vga.counterX    = x_q;
      vga.counterY    = y_q;
      vga.line_start  = vga.en && (x_q == '0);
      vga.frame_start = vga.en && (x_q == '0) && (y_q == '0);
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. dut_a uses a reduced raster
// (16+2+4+3 = 25 clocks per line, 6+1+2+2 = 11 lines, 275 clocks per frame,
// active-low syncs, PIX_LAT=2) so whole frames fit in a short run; dut_b uses
// the tiny 8x5 raster with active-high syncs and no pixel latency.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk25MHz = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total;
   int   bad;

   vga_timing_gen_if #(.CW(10)) bus_a ();
   vga_timing_gen_if #(.CW(10)) bus_b ();

   logic [7:0] rgb_a;
   logic [7:0] rgb_b;
   assign rgb_a = {bus_a.red, bus_a.green, bus_a.blue};
   assign rgb_b = {bus_b.red, bus_b.green, bus_b.blue};

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LAT(2), .CW(10)
   ) dut_a (
      .clk25MHz (clk25MHz),
      .rst      (rst_a),
      .vga      (bus_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(0), .CW(10)
   ) dut_b (
      .clk25MHz (clk25MHz),
      .rst      (rst_b),
      .vga      (bus_b)
   );

   // 10-unit pixel clock
   always #5 clk25MHz = ~clk25MHz;

   // Hard stop in case something stalls the sequence
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk25MHz);
      #2;
   endtask

   task automatic reset_a(input logic en_v);
      rst_a    = 1'b1;
      bus_a.en = en_v;
      tick();
      rst_a    = 1'b0;
   endtask

   // Reset values, and frame/line start following en while in reset state
   task automatic test_reset();
      bus_a.colors = 8'hFF;
      reset_a(1'b1);
      #1;
      total++; if (bus_a.counterX !== 10'd0) begin bad++; $display("[TB] FAIL reset_x: got %0d want 0", bus_a.counterX); end
      total++; if (bus_a.counterY !== 10'd0) begin bad++; $display("[TB] FAIL reset_y: got %0d want 0", bus_a.counterY); end
      total++; if (bus_a.hsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_hsync: got %b want 1", bus_a.hsync); end
      total++; if (bus_a.vsync !== 1'b1) begin bad++; $display("[TB] FAIL reset_vsync: got %b want 1", bus_a.vsync); end
      total++; if (rgb_a !== 8'h00) begin bad++; $display("[TB] FAIL reset_rgb: got %h want 00", rgb_a); end
      total++; if (bus_a.need_pixel !== 1'b1) begin bad++; $display("[TB] FAIL reset_need: got %b want 1", bus_a.need_pixel); end
      total++; if (bus_a.frame_start !== 1'b1) begin bad++; $display("[TB] FAIL reset_fs: got %b want 1", bus_a.frame_start); end
      total++; if (bus_a.line_start !== 1'b1) begin bad++; $display("[TB] FAIL reset_ls: got %b want 1", bus_a.line_start); end
      repeat (5) tick();
      rst_a    = 1'b1;
      bus_a.en = 1'b0;
      tick();
      rst_a    = 1'b0;
      #1;
      total++; if (bus_a.counterX !== 10'd0) begin bad++; $display("[TB] FAIL reset_en0_x: got %0d want 0", bus_a.counterX); end
      total++; if (bus_a.frame_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_en0_fs: got %b want 0", bus_a.frame_start); end
      total++; if (bus_a.line_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_en0_ls: got %b want 0", bus_a.line_start); end
      bus_a.en = 1'b1;
      #1;
      total++; if (bus_a.frame_start !== 1'b1) begin bad++; $display("[TB] FAIL reset_en1_fs: got %b want 1", bus_a.frame_start); end
   endtask

   // Two and a bit frames: period, hsync count/width/position, vsync width
   task automatic test_frame_timing();
      int   fs[$];
      logic hs_prev  = 1'b1;
      int   hs_run   = 0;
      int   vs_run   = 0;
      int   hs_first = -1;
      int   vs_first = -1;
      int   falls    = 0;
      int   bad_pos  = 0;
      int   max_y    = 0;
      int   period;
      bus_a.colors = 8'h00;
      reset_a(1'b1);
      #1;
      for (int c = 0; c < 600; c++) begin
         if (c > 0) begin tick(); #1; end
         if (bus_a.frame_start === 1'b1) fs.push_back(c);
         if (hs_prev === 1'b1 && bus_a.hsync === 1'b0) begin
            if (bus_a.counterX !== 10'd20) bad_pos++;
            if (fs.size() == 1) falls++;
         end
         if (bus_a.hsync === 1'b0) hs_run++;
         else begin
            if (hs_run > 0 && hs_first < 0) hs_first = hs_run;
            hs_run = 0;
         end
         if (bus_a.vsync === 1'b0) vs_run++;
         else begin
            if (vs_run > 0 && vs_first < 0) vs_first = vs_run;
            vs_run = 0;
         end
         if (int'(bus_a.counterY) > max_y) max_y = int'(bus_a.counterY);
         hs_prev = bus_a.hsync;
      end
      period = (fs.size() >= 2) ? fs[1] - fs[0] : -1;
      total++; if (fs.size() != 3) begin bad++; $display("[TB] FAIL frame_count: got %0d want 3", fs.size()); end
      total++; if (period != 275) begin bad++; $display("[TB] FAIL frame_period: got %0d want 275", period); end
      total++; if (falls != 11) begin bad++; $display("[TB] FAIL hsync_pulses: got %0d want 11", falls); end
      total++; if (bad_pos != 0) begin bad++; $display("[TB] FAIL hsync_start_pos: got %0d bad want 0", bad_pos); end
      total++; if (hs_first != 4) begin bad++; $display("[TB] FAIL hsync_width: got %0d want 4", hs_first); end
      total++; if (vs_first != 50) begin bad++; $display("[TB] FAIL vsync_width: got %0d want 50", vs_first); end
      total++; if (max_y != 10) begin bad++; $display("[TB] FAIL max_y: got %0d want 10", max_y); end
   endtask

   // Pixel source modelled with two cycles of latency; RGB must match the
   // requested pixel inside the window and be zero in every blanking region
   task automatic test_pixel_pipeline();
      int mx = 0, my = 0;
      int px1 = 0, py1 = 6, px2 = 0, py2 = 6;
      int pos_err = 0, act_err = 0, blank_err = 0;
      logic [7:0] cv;
      reset_a(1'b1);
      for (int i = 0; i < 300; i++) begin
         if (i > 0) begin
            tick();
            px2 = px1; py2 = py1;
            px1 = mx;  py1 = my;
            if (mx == 24) begin
               mx = 0;
               my = (my == 10) ? 0 : my + 1;
            end else begin
               mx++;
            end
         end
         cv = {px2[3:0], ~px2[3:0]};
         bus_a.colors = cv;
         #1;
         if (bus_a.counterX !== 10'(mx) || bus_a.counterY !== 10'(my)) pos_err++;
         if (px2 < 16 && py2 < 6) begin
            if (rgb_a !== cv) act_err++;
         end else begin
            if (rgb_a !== 8'h00) blank_err++;
         end
      end
      total++; if (pos_err != 0) begin bad++; $display("[TB] FAIL pipe_position: got %0d bad want 0", pos_err); end
      total++; if (act_err != 0) begin bad++; $display("[TB] FAIL pipe_rgb_active: got %0d bad want 0", act_err); end
      total++; if (blank_err != 0) begin bad++; $display("[TB] FAIL pipe_rgb_blank: got %0d bad want 0", blank_err); end
   endtask

   // en alternating 1,0: frame period doubles and nothing moves on held cycles
   task automatic test_en_toggle();
      logic [30:0] prev = '0, cur;
      logic        prev_en = 1'b1;
      int          fs[$];
      int          unstable = 0;
      int          p1, p2;
      bus_a.colors = 8'h5A;
      reset_a(1'b1);
      for (int i = 0; i < 1200; i++) begin
         if (i > 0) tick();
         bus_a.en = (i % 2 == 0);
         #1;
         cur = {bus_a.counterX, bus_a.counterY, bus_a.hsync, bus_a.vsync, rgb_a, bus_a.need_pixel};
         if (i > 0 && prev_en === 1'b0 && cur !== prev) unstable++;
         if (bus_a.frame_start === 1'b1) fs.push_back(i);
         prev    = cur;
         prev_en = bus_a.en;
      end
      bus_a.en = 1'b1;
      p1 = (fs.size() >= 2) ? fs[1] - fs[0] : -1;
      p2 = (fs.size() >= 3) ? fs[2] - fs[1] : -1;
      total++; if (p1 != 550) begin bad++; $display("[TB] FAIL en_period1: got %0d want 550", p1); end
      total++; if (p2 != 550) begin bad++; $display("[TB] FAIL en_period2: got %0d want 550", p2); end
      total++; if (unstable != 0) begin bad++; $display("[TB] FAIL en_hold: got %0d changes want 0", unstable); end
   endtask

   // Reset mid-frame at (10,3): restart at (0,0), blank for two enabled cycles
   task automatic test_mid_reset();
      int guard = 0;
      bus_a.colors = 8'hFF;
      reset_a(1'b1);
      #1;
      while (!(bus_a.counterX === 10'd10 && bus_a.counterY === 10'd3) && guard < 400) begin
         tick(); #1; guard++;
      end
      total++; if (guard >= 400) begin bad++; $display("[TB] FAIL midrst_reach: got timeout want x=10 y=3"); end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      #1;
      total++; if (bus_a.counterX !== 10'd0) begin bad++; $display("[TB] FAIL midrst_x: got %0d want 0", bus_a.counterX); end
      total++; if (bus_a.counterY !== 10'd0) begin bad++; $display("[TB] FAIL midrst_y: got %0d want 0", bus_a.counterY); end
      total++; if (bus_a.hsync !== 1'b1 || bus_a.vsync !== 1'b1) begin bad++; $display("[TB] FAIL midrst_sync: got %b%b want 11", bus_a.hsync, bus_a.vsync); end
      total++; if (rgb_a !== 8'h00) begin bad++; $display("[TB] FAIL midrst_rgb0: got %h want 00", rgb_a); end
      tick(); #1;
      total++; if (rgb_a !== 8'h00) begin bad++; $display("[TB] FAIL midrst_rgb1: got %h want 00", rgb_a); end
      tick(); #1;
      total++; if (rgb_a !== 8'hFF) begin bad++; $display("[TB] FAIL midrst_rgb2: got %h want ff", rgb_a); end
   endtask

   // Last pixel of the frame rolls over to (0,0) with both start markers
   task automatic test_wrap();
      int guard = 0;
      bus_a.en = 1'b1;
      #1;
      while (!(bus_a.counterX === 10'd24 && bus_a.counterY === 10'd10) && guard < 400) begin
         tick(); #1; guard++;
      end
      total++; if (guard >= 400) begin bad++; $display("[TB] FAIL wrap_reach: got timeout want x=24 y=10"); end
      tick(); #1;
      total++; if (bus_a.counterX !== 10'd0 || bus_a.counterY !== 10'd0) begin bad++; $display("[TB] FAIL wrap_pos: got %0d,%0d want 0,0", bus_a.counterX, bus_a.counterY); end
      total++; if (bus_a.frame_start !== 1'b1) begin bad++; $display("[TB] FAIL wrap_fs: got %b want 1", bus_a.frame_start); end
      total++; if (bus_a.line_start !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ls: got %b want 1", bus_a.line_start); end
   endtask

   // Tiny raster, active-high syncs, no latency
   task automatic test_small();
      int mx = 0, my = 0;
      int pos_err = 0, hs_err = 0, vs_err = 0, rgb_err = 0;
      int hs_hi = 0, vs_hi = 0, period;
      int fs[$];
      bus_b.colors = 8'hA5;
      bus_b.en     = 1'b1;
      rst_b        = 1'b1;
      tick();
      rst_b        = 1'b0;
      #1;
      for (int i = 0; i < 80; i++) begin
         if (i > 0) begin
            tick(); #1;
            if (mx == 7) begin
               mx = 0;
               my = (my == 4) ? 0 : my + 1;
            end else begin
               mx++;
            end
         end
         if (bus_b.counterX !== 10'(mx) || bus_b.counterY !== 10'(my)) pos_err++;
         if (bus_b.hsync !== ((mx == 5 || mx == 6) ? 1'b1 : 1'b0)) hs_err++;
         if (bus_b.vsync !== ((my == 3) ? 1'b1 : 1'b0)) vs_err++;
         if (rgb_b !== ((mx < 4 && my < 2) ? 8'hA5 : 8'h00)) rgb_err++;
         if (bus_b.hsync === 1'b1) hs_hi++;
         if (bus_b.vsync === 1'b1) vs_hi++;
         if (bus_b.frame_start === 1'b1) fs.push_back(i);
      end
      period = (fs.size() >= 2) ? fs[1] - fs[0] : -1;
      total++; if (pos_err != 0) begin bad++; $display("[TB] FAIL small_pos: got %0d bad want 0", pos_err); end
      total++; if (hs_err != 0) begin bad++; $display("[TB] FAIL small_hsync: got %0d bad want 0", hs_err); end
      total++; if (vs_err != 0) begin bad++; $display("[TB] FAIL small_vsync: got %0d bad want 0", vs_err); end
      total++; if (rgb_err != 0) begin bad++; $display("[TB] FAIL small_rgb: got %0d bad want 0", rgb_err); end
      total++; if (hs_hi != 20) begin bad++; $display("[TB] FAIL small_hs_high: got %0d want 20", hs_hi); end
      total++; if (vs_hi != 16) begin bad++; $display("[TB] FAIL small_vs_high: got %0d want 16", vs_hi); end
      total++; if (period != 40) begin bad++; $display("[TB] FAIL small_period: got %0d want 40", period); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst_a        = 1'b0;
      rst_b        = 1'b1;
      bus_a.en     = 1'b0;
      bus_a.colors = 8'h00;
      bus_b.en     = 1'b0;
      bus_b.colors = 8'h00;
      tick();
      rst_b        = 1'b0;
      $display("[TB] starting vga_timing_gen directed tests");
      test_reset();
      test_frame_timing();
      test_pixel_pipeline();
      test_en_toggle();
      test_mid_reset();
      test_wrap();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
